// File: rtl/cdb_pkg.sv
// Shared CDB definitions: widths, broadcast payload type, FU index constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cdb_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ID_W   = 5;
    localparam int ISS_ID_W   = 8;
    localparam int FU_ID_W    = 4;

    // Broadcast record seen by reservation stations, ROB and rename logic
    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] value;
        logic [REG_ID_W-1:0]   reg_id;
        logic [FU_ID_W-1:0]    fu_id;
        logic [ISS_ID_W-1:0]   iss_id;
    } cdb_payload_t;

    // Constant FU ids wired into the execution units
    localparam logic [FU_ID_W-1:0] FU_ALU0 = 4'd0;
    localparam logic [FU_ID_W-1:0] FU_ALU1 = 4'd1;
    localparam logic [FU_ID_W-1:0] FU_MUL  = 4'd2;
    localparam logic [FU_ID_W-1:0] FU_LSU  = 4'd3;

    // FU index increment modulo the real FU count, not the index width
    function automatic int fu_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Round-robin arbiter: one-hot grant and winner index from N request lines.
// Latency: grant is combinational from i_req; pointer advances on the clock.
// Backpressure: losers receive no grant and are expected to hold their request.
module rr_arbiter
    import cdb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     i_req,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_win,
    output logic             o_gnt_vld
);

    logic [IDX_W-1:0] r_ptr;
    logic [N-1:0]     w_mask;
    logic [2*N-1:0]   w_dbl;
    logic             w_hit;
    logic [IDX_W-1:0] w_win;

    // Lower half keeps only requests at/after the pointer, upper half all of
    // them; the lowest set bit of the doubled vector is the round-robin winner.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (i >= int'(r_ptr));
        end
        w_dbl = {i_req, i_req & w_mask};
        w_hit = 1'b0;
        w_win = '0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (w_dbl[i]) begin
                w_hit = 1'b1;
                w_win = IDX_W'(i % N);
            end
        end
    end

    // A grant raised while reset is high is void
    assign o_gnt_vld = w_hit & ~reset;
    assign o_grant   = o_gnt_vld ? (N'(1) << w_win) : '0;
    assign o_win     = w_win;

    // Priority moves to the FU just after the winner; held when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (o_gnt_vld) begin
            r_ptr <= IDX_W'(fu_wrap_inc(int'(w_win), N));
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant among FUs, registered broadcast.
// Latency: fu_ack same cycle as fu_req; broadcast one cycle after the grant.
// Backpressure: non-granted FUs hold fu_req and payload until acked.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_FU     = 4,
    parameter int DATA_WIDTH = cdb_pkg::DATA_WIDTH,
    parameter int REG_ID_W   = cdb_pkg::REG_ID_W,
    parameter int ISS_ID_W   = cdb_pkg::ISS_ID_W,
    parameter int FU_ID_W    = cdb_pkg::FU_ID_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_FU-1:0]            fu_req,
    output logic [NUM_FU-1:0]            fu_ack,
    input  logic [NUM_FU*DATA_WIDTH-1:0] fu_value,
    input  logic [NUM_FU*REG_ID_W-1:0]   fu_reg_id,
    input  logic [NUM_FU*ISS_ID_W-1:0]   fu_iss_id,
    input  logic                         flush,
    output logic                         cdb_valid,
    output logic [DATA_WIDTH-1:0]        cdb_value,
    output logic [REG_ID_W-1:0]          cdb_reg_id,
    output logic [FU_ID_W-1:0]           cdb_fu_id,
    output logic [ISS_ID_W-1:0]          cdb_iss_id
);

    logic [FU_ID_W-1:0]    w_win;
    logic                  w_gnt_vld;
    logic [DATA_WIDTH-1:0] w_value;
    logic [REG_ID_W-1:0]   w_reg_id;
    logic [ISS_ID_W-1:0]   w_iss_id;

    logic                  r_cdb_valid;
    logic [DATA_WIDTH-1:0] r_cdb_value;
    logic [REG_ID_W-1:0]   r_cdb_reg_id;
    logic [FU_ID_W-1:0]    r_cdb_fu_id;
    logic [ISS_ID_W-1:0]   r_cdb_iss_id;

    rr_arbiter #(
        .N     (NUM_FU),
        .IDX_W (FU_ID_W)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .i_req     (fu_req),
        .o_grant   (fu_ack),
        .o_win     (w_win),
        .o_gnt_vld (w_gnt_vld)
    );

    // Winner's payload slices
    always_comb begin
        w_value  = fu_value[w_win*DATA_WIDTH +: DATA_WIDTH];
        w_reg_id = fu_reg_id[w_win*REG_ID_W +: REG_ID_W];
        w_iss_id = fu_iss_id[w_win*ISS_ID_W +: ISS_ID_W];
    end

    // Broadcast register: flushed grants still drain but are never marked valid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cdb_valid  <= 1'b0;
            r_cdb_value  <= '0;
            r_cdb_reg_id <= '0;
            r_cdb_fu_id  <= '0;
            r_cdb_iss_id <= '0;
        end else if (w_gnt_vld) begin
            r_cdb_valid  <= ~flush;
            r_cdb_value  <= w_value;
            r_cdb_reg_id <= w_reg_id;
            r_cdb_fu_id  <= w_win;
            r_cdb_iss_id <= w_iss_id;
        end else begin
            r_cdb_valid  <= 1'b0;
        end
    end

    assign cdb_valid  = r_cdb_valid;
    assign cdb_value  = r_cdb_value;
    assign cdb_reg_id = r_cdb_reg_id;
    assign cdb_fu_id  = r_cdb_fu_id;
    assign cdb_iss_id = r_cdb_iss_id;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: reference arbiter model plus broadcast scoreboard.
// Latency: expected broadcast pushed on the grant cycle, popped one cycle later.
// Backpressure: modelled FUs hold request and payload until they see an ack.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int IW = 8;
    localparam int FW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic [N-1:0]    fu_req;
    logic [N-1:0]    fu_ack;
    logic [N*DW-1:0] fu_value;
    logic [N*RW-1:0] fu_reg_id;
    logic [N*IW-1:0] fu_iss_id;
    logic            cdb_valid;
    logic [DW-1:0]   cdb_value;
    logic [RW-1:0]   cdb_reg_id;
    logic [FW-1:0]   cdb_fu_id;
    logic [IW-1:0]   cdb_iss_id;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .NUM_FU(N), .DATA_WIDTH(DW), .REG_ID_W(RW), .ISS_ID_W(IW), .FU_ID_W(FW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fu_req     (fu_req),
        .fu_ack     (fu_ack),
        .fu_value   (fu_value),
        .fu_reg_id  (fu_reg_id),
        .fu_iss_id  (fu_iss_id),
        .flush      (flush),
        .cdb_valid  (cdb_valid),
        .cdb_value  (cdb_value),
        .cdb_reg_id (cdb_reg_id),
        .cdb_fu_id  (cdb_fu_id),
        .cdb_iss_id (cdb_iss_id)
    );

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] value;
        logic [RW-1:0] reg_id;
        logic [FW-1:0] fu_id;
        logic [IW-1:0] iss_id;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         m_cdb;
    int           m_ptr;
    logic [N-1:0] pend;
    logic [N-1:0] sticky;
    logic [DW-1:0] pv[N];
    logic [RW-1:0] pr[N];
    logic [IW-1:0] pt[N];
    int           waits[N];
    int           n_vec;
    int           n_err;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic raise(input int i, input logic [DW-1:0] v, input logic [RW-1:0] r,
                         input logic [IW-1:0] t);
        pend[i] = 1'b1;
        pv[i]   = v;
        pr[i]   = r;
        pt[i]   = t;
    endtask

    task automatic raise_rand(input int i);
        raise(i, $urandom, RW'($urandom), IW'($urandom));
    endtask

    // One clock: drive, check ack and the broadcast due now, advance the model
    task automatic cycle();
        exp_t         e;
        logic [N-1:0] eack;
        logic [N-1:0] got;
        int           w;
        int           idx;
        bit           hit;
        fu_req = pend;
        for (int i = 0; i < N; i++) begin
            fu_value[i*DW +: DW]  = pv[i];
            fu_reg_id[i*RW +: RW] = pr[i];
            fu_iss_id[i*IW +: IW] = pt[i];
        end
        #3;
        hit  = 1'b0;
        w    = 0;
        eack = '0;
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!hit && pend[idx]) begin
                    hit = 1'b1;
                    w   = idx;
                end
            end
        end
        if (hit) eack[w] = 1'b1;
        got = fu_ack;
        chk("fu_ack", 64'(got), 64'(eack));
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("cdb_valid",  64'(cdb_valid),  64'(e.valid));
            chk("cdb_value",  64'(cdb_value),  64'(e.value));
            chk("cdb_reg_id", 64'(cdb_reg_id), 64'(e.reg_id));
            chk("cdb_fu_id",  64'(cdb_fu_id),  64'(e.fu_id));
            chk("cdb_iss_id", 64'(cdb_iss_id), 64'(e.iss_id));
        end
        if (reset) begin
            m_cdb = '0;
            m_ptr = 0;
        end else if (hit) begin
            m_cdb.valid  = !flush;
            m_cdb.value  = pv[w];
            m_cdb.reg_id = pr[w];
            m_cdb.fu_id  = FW'(w);
            m_cdb.iss_id = pt[w];
            m_ptr = (w + 1) % N;
        end else begin
            m_cdb.valid = 1'b0;
        end
        sb_q.push_back(m_cdb);
        for (int i = 0; i < N; i++) begin
            if (got[i]) waits[i] = 0;
            else if (pend[i]) waits[i]++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (got[i] && !sticky[i]) pend[i] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        n_vec = 0; n_err = 0; m_ptr = 0; m_cdb = '0;
        pend = '0; sticky = '0; reset = 1'b1; flush = 1'b0;
        fu_req = '0; fu_value = '0; fu_reg_id = '0; fu_iss_id = '0;
        for (int i = 0; i < N; i++) begin
            pv[i] = '0; pr[i] = '0; pt[i] = '0; waits[i] = 0;
        end
        #1;
        idle(2);
        reset = 1'b0;
        idle(1);

        // Single requester FU2
        raise(2, 32'hDEADBEEF, 5'd7, 8'h12);
        idle(3);

        // All four from reset, each drops after its ack
        reset = 1'b1; idle(1); reset = 1'b0;
        for (int i = 0; i < N; i++) raise_rand(i);
        idle(5);

        // Move pointer to 3 via FU2, then contention 1001 across the wrap
        raise_rand(2); idle(1);
        raise_rand(0); raise_rand(3);
        idle(3);

        // Grant during flush is discarded
        raise_rand(0); flush = 1'b1; idle(1); flush = 1'b0;
        idle(2);

        // Reset in the middle of a full request burst
        for (int i = 0; i < N; i++) raise_rand(i);
        sticky = '1;
        idle(2);
        reset = 1'b1; idle(1); reset = 1'b0;
        sticky = '0;
        idle(5);

        // Two continuous requesters must alternate
        for (int i = 0; i < N; i++) waits[i] = 0;
        raise_rand(0); raise_rand(1); sticky = 4'b0011;
        for (int c = 0; c < 20; c++) begin
            cycle();
            chk("starve_wait", 64'(waits[0] <= 2 && waits[1] <= 2), 64'd1);
        end
        sticky = '0;
        idle(3);

        // Random traffic with occasional flush
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) raise_rand(i);
            end
            flush = ($urandom_range(0, 4) == 0);
            cycle();
            for (int i = 0; i < N; i++) begin
                chk("rand_wait", 64'(waits[i] <= N), 64'd1);
            end
        end
        flush = 1'b0;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus arbiter. This block is the responder for the per-functional-unit CDB_REQ/CDB_ACK handshake. It takes request lines from up to NUM_FU execution units and grants the bus to exactly one of them per cycle, using round-robin priority. It captures the granted unit's payload and broadcasts it, registered, to the reservation stations, ROB and register-rename logic.

## Interface
Parameters:
- NUM_FU, 4, number of requesting functional units (2..16)
- DATA_WIDTH, 32, result value width
- REG_ID_W, 5, destination architectural register id width
- ISS_ID_W, 8, issue/WAW tag width
- FU_ID_W, 4, FU index width; must satisfy 2**FU_ID_W >= NUM_FU

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- fu_req  in  NUM_FU  per-FU CDB request, held high by the FU until acknowledged
- fu_ack  out  NUM_FU  per-FU grant, one-hot or zero, combinational
- fu_value  in  NUM_FU*DATA_WIDTH  flattened per-FU result; slice i is valid while fu_ack[i]
- fu_reg_id  in  NUM_FU*REG_ID_W  flattened per-FU destination register
- fu_iss_id  in  NUM_FU*ISS_ID_W  flattened per-FU issue tag
- flush  in  1  mispredict squash; suppresses broadcast
- cdb_valid  out  1  broadcast valid, registered
- cdb_value  out  DATA_WIDTH  broadcast result
- cdb_reg_id  out  REG_ID_W  broadcast destination register
- cdb_fu_id  out  FU_ID_W  index of the FU that won
- cdb_iss_id  out  ISS_ID_W  broadcast issue tag

## Operation
- Round-robin pointer `rr_ptr` (FU_ID_W bits) marks the highest-priority FU.
- Grant search order is rr_ptr, rr_ptr+1, …, NUM_FU-1, 0, …, rr_ptr-1. The first FU with fu_req=1 wins.
- fu_ack = onehot(winner) when any request is present and reset=0. Otherwise fu_ack=0.
- On every grant, rr_ptr <= winner+1, wrapping from NUM_FU-1 to 0. With no grant, rr_ptr is held.
- Payload capture: on the grant cycle, the winner's value, reg_id and iss_id slices plus the winner index are registered into the cdb_* outputs.
  - cdb_valid <= grant & ~flush.
- With no grant, cdb_valid <= 0 and the cdb_* data fields hold their last values.
- An FU that is not acked keeps fu_req high and holds its payload stable. The arbiter never drops a request.
- A pending request is granted within NUM_FU cycles (starvation bound).
- Flush:
  - Grants continue normally during flush so FUs drain their stalled results.
  - Payloads granted in a flush cycle are discarded (cdb_valid=0 the next cycle).
  - Flush does not modify rr_ptr.
- fu_req bits at index >= NUM_FU do not exist. The FU index arithmetic is modulo NUM_FU, not 2**FU_ID_W.

## Timing
- Reset values: rr_ptr=0, cdb_valid=0, cdb_value=0, cdb_reg_id=0, cdb_fu_id=0, cdb_iss_id=0. fu_ack=0 combinationally while reset=1.
- fu_ack has zero latency: it asserts in the same cycle as the qualifying fu_req.
- Broadcast latency: a payload granted in cycle t appears with cdb_valid=1 in cycle t+1 and stays for exactly one cycle.
- Throughput: one broadcast per cycle. Back-to-back grants produce back-to-back cdb_valid.
- When the same FU requests continuously and others are idle, it is acked every cycle.
- Simultaneous requests: exactly one ack. The losers see ack=0 and must keep fu_req held.
- Reset mid-operation: any grant in the reset cycle is void. cdb_valid=0 from the cycle after reset is asserted. rr_ptr restarts at 0.
- Reset has priority over flush. flush and grant in the same cycle: the ack is still given, and cdb_valid=0 next cycle.

## Structure
- Package cdb_pkg holds:
  - the width constants DATA_WIDTH, REG_ID_W, ISS_ID_W, FU_ID_W;
  - typedef cdb_payload_t {valid, value, reg_id, fu_id, iss_id}, shared with reservation stations and the ROB;
  - the FU index localparams, e.g. FU_ALU0=0, shared with the execution units' constant FU id.
- One sub-module, rr_arbiter. It is parameterised by N, takes req[N] and returns grant one-hot plus the winner index. It owns rr_ptr and its update, and uses the double-width masked priority-encode technique.
- Top level: rr_arbiter, the payload mux driven by the winner index, and the output register stage.

## Test plan
- Single requester: reset, then fu_req=4'b0100 with value 0xDEADBEEF, reg 7, tag 0x12, held for one cycle. Required: fu_ack=4'b0100 in the same cycle. Next cycle cdb_valid=1, cdb_value=0xDEADBEEF, cdb_reg_id=7, cdb_fu_id=2, cdb_iss_id=0x12. The cycle after, cdb_valid=0.
- All four requesting from reset, each deasserting fu_req after its ack. Required: acks in order 0,1,2,3 on consecutive cycles, and four consecutive broadcasts with cdb_fu_id 0,1,2,3.
- Contention with wrap: rr_ptr=3 and fu_req=4'b1001. Required: FU3 acked first, then FU0. rr_ptr wraps to 0, then 1.
- Flush: fu_req=4'b0001 with flush=1 in the same cycle. Required: fu_ack=4'b0001, cdb_valid=0 next cycle, rr_ptr=1.
- Reset mid-stream: all FUs requesting, reset asserted for one cycle. Required: fu_ack=0 during reset, cdb_valid=0 the next cycle, and the first post-reset grant goes to FU0.
- Starvation: FU0 and FU1 request continuously for 20 cycles. Required: acks alternate 0,1,0,1…, with no FU waiting more than 2 cycles.
